// File: rtl/vram_arbiter_if.sv
// Bundles the renderer, CPU register-port and VRAM signals of vram_arbiter.
// slave is the arbiter's view, master is the surrounding system's view.
interface vram_arbiter_if;
  logic        vblank;
  logic        rnd_req;
  logic [15:0] rnd_addr;
  logic        rnd_grant;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  vblank, rnd_req, rnd_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output rnd_grant, cpu_busy, cpu_done, cpu_rdata,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vblank, rnd_req, rnd_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  rnd_grant, cpu_busy, cpu_done, cpu_rdata,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single VRAM port shared by the renderer (priority) and a one-entry CPU access buffer.
// Define VRAM_ARB_STARVE_GUARD_EN to force a CPU slot after STARVE_LIMIT blocked PEND cycles.
module vram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] buf_addr_reg;
  logic        buf_we_reg;
  logic [7:0]  buf_wdata_reg;
  logic        done_reg;
  logic [7:0]  rdata_reg;

  logic capture;
  logic force_slot;
  logic rnd_win;
  logic issue;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("vram_arbiter: STARVE_LIMIT must be at least 1");
  end

  assign capture = (state_reg == IDLE) && bus.cpu_req;
  assign rnd_win = !bus.vblank && bus.rnd_req && !force_slot;
  assign issue   = (state_reg == PEND) && !rnd_win;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_reg;

  assign force_slot = (state_reg == PEND) && (starve_cnt_reg >= CNT_W'(STARVE_LIMIT));

  // Counts only renderer wins while a CPU access waits; any issue restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_reg <= '0;
    end else if (issue) begin
      starve_cnt_reg <= '0;
    end else if ((state_reg == PEND) && rnd_win) begin
      starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
    end
  end
`else
  assign force_slot = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_addr_reg  <= 16'h0000;
      buf_we_reg    <= 1'b0;
      buf_wdata_reg <= 8'h00;
      done_reg      <= 1'b0;
      rdata_reg     <= 8'h00;
    end else begin
      if (capture) begin
        buf_addr_reg  <= bus.cpu_addr;
        buf_we_reg    <= bus.cpu_we;
        buf_wdata_reg <= bus.cpu_wdata;
      end
      // Write completes the cycle after issue; read one cycle later, after RD_WAIT.
      done_reg <= (issue && buf_we_reg) || (state_reg == RD_WAIT);
      if (state_reg == RD_WAIT) begin
        rdata_reg <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (capture) state_next = PEND;
      PEND:    if (issue)   state_next = buf_we_reg ? IDLE : RD_WAIT;
      RD_WAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Port outputs are combinational, so they are also gated by reset directly.
  always_comb begin
    bus.rnd_grant = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 8'h00;
    if (reset) begin
      bus.rnd_grant = rnd_win;
      if (issue) begin
        bus.mem_addr  = buf_addr_reg;
        bus.mem_we    = buf_we_reg;
        bus.mem_wdata = buf_wdata_reg;
      end else begin
        bus.mem_addr  = bus.rnd_addr;
      end
    end
  end

  always_comb begin
    bus.cpu_busy  = (state_reg != IDLE);
    bus.cpu_done  = done_reg;
    bus.cpu_rdata = rdata_reg;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a vector table plus hand sequences for
// starvation and mid-operation reset, with a simple synchronous VRAM model.
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  vram_arbiter_if bus ();

  vram_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // VRAM model: one-cycle registered read; unwritten locations hold preload values.
  bit [7:0] vram     [0:65535];
  bit       wr_valid [0:65535];

  function automatic logic [7:0] preload(input logic [15:0] a);
    return (a == 16'h23C0) ? 8'hA7 : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_we) begin
      vram[bus.mem_addr]     <= bus.mem_wdata;
      wr_valid[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= wr_valid[bus.mem_addr] ? vram[bus.mem_addr] : preload(bus.mem_addr);
  end

  typedef struct {
    logic        vb;
    logic        rr;
    logic [15:0] ra;
    logic        cr;
    logic        cw;
    logic [15:0] ca;
    logic [7:0]  cd;
    logic [35:0] exp;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [35:0] e(input logic g, input logic [15:0] ma, input logic we,
                                    input logic [7:0] wd, input logic bsy, input logic dn,
                                    input logic [7:0] rd);
    return {g, ma, we, wd, bsy, dn, rd};
  endfunction

  function automatic logic [35:0] outs();
    return {bus.rnd_grant, bus.mem_addr, bus.mem_we, bus.mem_wdata,
            bus.cpu_busy, bus.cpu_done, bus.cpu_rdata};
  endfunction

  task automatic check_outs(input string name, input logic [35:0] exp);
    logic [35:0] act;
    act = outs();
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got gnt/addr/we/wd/busy/done/rd=%h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vb, input logic rr, input logic [15:0] ra,
                       input logic cr, input logic cw, input logic [15:0] ca,
                       input logic [7:0] cd);
    bus.vblank    = vb;
    bus.rnd_req   = rr;
    bus.rnd_addr  = ra;
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
  endtask

  vec_t vecs [23];

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int EXP_ISSUE = 9;
`else
  localparam int EXP_ISSUE = 10;
`endif

  initial begin
    int issue_cyc;
    int done_cyc;
    int grant_cnt;
    int bad_cnt;
    logic [15:0] issue_addr;
    logic [7:0]  rd_val;

    vecs[0]  = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b1, 16'h2000, 8'h5A, e(0, 16'h1111, 0, 8'h00, 0, 0, 8'h00)};
    vecs[1]  = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b1, 16'h3000, 8'h33, e(0, 16'h2000, 1, 8'h5A, 1, 0, 8'h00)};
    vecs[2]  = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h1111, 0, 8'h00, 0, 1, 8'h00)};
    vecs[3]  = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h1111, 0, 8'h00, 0, 0, 8'h00)};
    vecs[4]  = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 16'h23C0, 8'hFF, e(0, 16'h1111, 0, 8'h00, 0, 0, 8'h00)};
    vecs[5]  = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h23C0, 0, 8'hFF, 1, 0, 8'h00)};
    vecs[6]  = '{1'b0, 1'b1, 16'h0400, 1'b0, 1'b0, 16'h0000, 8'h00, e(1, 16'h0400, 0, 8'h00, 1, 0, 8'h00)};
    vecs[7]  = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h1111, 0, 8'h00, 0, 1, 8'hA7)};
    vecs[8]  = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h1111, 0, 8'h00, 0, 0, 8'hA7)};
    vecs[9]  = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 16'h2000, 8'h00, e(0, 16'h1111, 0, 8'h00, 0, 0, 8'hA7)};
    vecs[10] = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h2000, 0, 8'h00, 1, 0, 8'hA7)};
    vecs[11] = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h1111, 0, 8'h00, 1, 0, 8'hA7)};
    vecs[12] = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h1111, 0, 8'h00, 0, 1, 8'h5A)};
    vecs[13] = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 16'h3000, 8'h00, e(0, 16'h1111, 0, 8'h00, 0, 0, 8'h5A)};
    vecs[14] = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h3000, 0, 8'h00, 1, 0, 8'h5A)};
    vecs[15] = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h1111, 0, 8'h00, 1, 0, 8'h5A)};
    vecs[16] = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h1111, 0, 8'h00, 0, 1, 8'h00)};
    vecs[17] = '{1'b0, 1'b1, 16'h0500, 1'b1, 1'b1, 16'h2100, 8'hC3, e(1, 16'h0500, 0, 8'h00, 0, 0, 8'h00)};
    vecs[18] = '{1'b0, 1'b1, 16'h0500, 1'b0, 1'b0, 16'h0000, 8'h00, e(1, 16'h0500, 0, 8'h00, 1, 0, 8'h00)};
    vecs[19] = '{1'b1, 1'b1, 16'h0500, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h2100, 1, 8'hC3, 1, 0, 8'h00)};
    vecs[20] = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h1111, 0, 8'h00, 0, 1, 8'h00)};
    vecs[21] = '{1'b0, 1'b0, 16'h0777, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h0777, 0, 8'h00, 0, 0, 8'h00)};
    vecs[22] = '{1'b1, 1'b1, 16'h0888, 1'b0, 1'b0, 16'h0000, 8'h00, e(0, 16'h0888, 0, 8'h00, 0, 0, 8'h00)};

    // Reset state, with the renderer and CPU inputs busy to show they are masked.
    drive(1'b0, 1'b1, 16'hABCD, 1'b1, 1'b1, 16'h2000, 8'hEE);
    #3;
    check_outs("reset_async", e(0, 16'h0000, 0, 8'h00, 0, 0, 8'h00));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_outs("reset_held", e(0, 16'h0000, 0, 8'h00, 0, 0, 8'h00));
    drive(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000, 8'h00);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].vb, vecs[i].rr, vecs[i].ra, vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].exp);
      tick();
    end

    // Renderer saturates the port for cycles 0-9 while a CPU write waits.
    issue_cyc  = -1;
    done_cyc   = -1;
    grant_cnt  = 0;
    issue_addr = 16'h0000;
    drive(1'b0, 1'b1, 16'h0600, 1'b1, 1'b1, 16'h2200, 8'h77);
    for (int k = 0; k < 14; k++) begin
      if (k == 1) bus.cpu_req = 1'b0;
      if (k == 10) begin
        bus.rnd_req = 1'b0;
        bus.vblank  = 1'b1;
      end
      @(negedge clk);
      if (k < 10 && bus.rnd_grant) grant_cnt++;
      if (bus.mem_we && issue_cyc < 0) begin
        issue_cyc  = k;
        issue_addr = bus.mem_addr;
        if (k < 10 && bus.rnd_grant) grant_cnt = grant_cnt + 100;
      end
      if (bus.cpu_done && done_cyc < 0) done_cyc = k;
      tick();
    end
    check_int("starve_issue_cycle", issue_cyc, EXP_ISSUE);
    check_int("starve_issue_addr", int'(issue_addr), 16'h2200);
    check_int("starve_grant_cycles", grant_cnt, EXP_ISSUE);
    check_int("starve_done_cycle", done_cyc, EXP_ISSUE + 1);

    // Read captured, then reset asserted during its issue cycle.
    drive(1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 16'h23C0, 8'h00);
    tick();
    bus.cpu_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_outs("midop_reset", e(0, 16'h0000, 0, 8'h00, 0, 0, 8'h00));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bad_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      if (bus.cpu_done || bus.mem_we || bus.cpu_busy) bad_cnt++;
    end
    check_int("midop_no_completion", bad_cnt, 0);

    // Next read after release completes normally.
    tick();
    drive(1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 16'h2000, 8'h00);
    done_cyc = -1;
    rd_val   = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) bus.cpu_req = 1'b0;
      @(negedge clk);
      if (bus.cpu_done && done_cyc < 0) begin
        done_cyc = k;
        rd_val   = bus.cpu_rdata;
      end
      tick();
    end
    check_int("post_reset_read_latency", done_cyc, 3);
    check_int("post_reset_read_data", int'(rd_val), 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
